// File: rtl/fdd_track_ctrl.sv
// Floppy track-buffer sequencer: loads a track of sectors from SD port 0 into the track RAM.
// Define FDD_WRITEBACK_EN to track dirty sectors and write them back before a track is replaced.
module fdd_track_ctrl #(
   parameter int SECTORS = 13,
   parameter int TRACK_W = 6,
   parameter int SEC_W   = 4
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [TRACK_W-1:0] track,
   input  logic               img_mounted,
   input  logic               img_present,
   input  logic               img_readonly,
   input  logic               disk_we,
   input  logic [SEC_W+8:0]   disk_addr,
   output logic [31:0]        sd_lba,
   output logic               sd_rd,
   output logic               sd_wr,
   input  logic               sd_ack,
   output logic [SEC_W-1:0]   buf_sec,
   output logic               cpu_wait,
   output logic               busy,
   output logic [SECTORS-1:0] dirty
);
   typedef enum logic [2:0] {IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER} state_t;
   localparam logic [SEC_W-1:0] LAST_SEC = SEC_W'(SECTORS - 1);

   state_t             state_reg, state_next;
   logic [TRACK_W-1:0] cur_track_reg, cur_track_next;
   logic [SEC_W-1:0]   buf_sec_reg, buf_sec_next;
   logic [31:0]        sd_lba_reg, sd_lba_next;
   logic               sd_rd_reg, sd_rd_next;
   logic               sd_wr_reg, sd_wr_next;
   logic               cpu_wait_reg, cpu_wait_next;
   logic               loaded_reg, loaded_next;
   logic               mount_pend_reg, mount_pend_next;
   logic               abort_reg, abort_next;
   logic               ack_q;
   logic               ack_rise, ack_fall;
   logic               mount_eff, need_load, start_flush;
   logic               clr_all, clr_one;
   logic [31:0]        lba_calc;
   logic [SECTORS-1:0] dirty_reg;

`ifdef FDD_WRITEBACK_EN
   logic [SECTORS-1:0] dirty_next, set_vec, clr_vec, remaining;
   logic [SEC_W-1:0]   wr_sec;

   function automatic logic [SEC_W-1:0] lowest(input logic [SECTORS-1:0] v);
      lowest = '0;
      for (int i = SECTORS - 1; i >= 0; i--)
         if (v[i]) lowest = SEC_W'(i);
   endfunction

   assign wr_sec = disk_addr[SEC_W+8:9];

   // Sector indices at or above SECTORS have no bit and are silently dropped.
   genvar gi;
   generate
      for (gi = 0; gi < SECTORS; gi++) begin : g_dirty_set
         assign set_vec[gi] = disk_we && (wr_sec == SEC_W'(gi));
      end
   endgenerate

   assign remaining   = dirty_reg | set_vec;
   assign start_flush = need_load & (dirty_reg != '0) & ~img_readonly & ~mount_eff;

   always_comb begin
      clr_vec = '0;
      if (clr_all || img_mounted)
         clr_vec = '1;
      else if (clr_one)
         clr_vec = SECTORS'(1) << buf_sec_reg;
      dirty_next = (dirty_reg & ~clr_vec) | set_vec;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)
         dirty_reg <= '0;
      else
         dirty_reg <= dirty_next;
   end
`else
   logic unused_wb;
   assign unused_wb   = &{1'b0, disk_we, disk_addr, img_readonly, clr_all, clr_one};
   assign dirty_reg   = '0;
   assign start_flush = 1'b0;
`endif

   assign ack_rise  = sd_ack & ~ack_q;
   assign ack_fall  = ~sd_ack & ack_q;
   assign mount_eff = mount_pend_reg | img_mounted;
   assign need_load = img_present & (mount_eff | ~loaded_reg | (track != cur_track_reg));
   assign lba_calc  = 32'(SECTORS) * 32'(cur_track_reg) + 32'(buf_sec_reg);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         cur_track_reg  <= '0;
         buf_sec_reg    <= '0;
         sd_lba_reg     <= '0;
         sd_rd_reg      <= 1'b0;
         sd_wr_reg      <= 1'b0;
         cpu_wait_reg   <= 1'b0;
         loaded_reg     <= 1'b0;
         mount_pend_reg <= 1'b0;
         abort_reg      <= 1'b0;
         ack_q          <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cur_track_reg  <= cur_track_next;
         buf_sec_reg    <= buf_sec_next;
         sd_lba_reg     <= sd_lba_next;
         sd_rd_reg      <= sd_rd_next;
         sd_wr_reg      <= sd_wr_next;
         cpu_wait_reg   <= cpu_wait_next;
         loaded_reg     <= loaded_next;
         mount_pend_reg <= mount_pend_next;
         abort_reg      <= abort_next;
         ack_q          <= sd_ack;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start_flush)    state_next = FLUSH_REQ;
            else if (need_load) state_next = LOAD_REQ;
         end
`ifdef FDD_WRITEBACK_EN
         FLUSH_REQ:  if (ack_rise) state_next = FLUSH_XFER;
         FLUSH_XFER: begin
            if (ack_fall) begin
               if (abort_reg)              state_next = IDLE;
               else if (remaining != '0)   state_next = FLUSH_REQ;
               else                        state_next = LOAD_REQ;
            end
         end
`endif
         LOAD_REQ:   if (ack_rise) state_next = LOAD_XFER;
         LOAD_XFER: begin
            if (ack_fall) begin
               if (abort_reg || buf_sec_reg == LAST_SEC) state_next = IDLE;
               else                                      state_next = LOAD_REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath next values; a mount seen mid-sequence lets the current block finish, then restarts.
   always_comb begin
      cur_track_next  = cur_track_reg;
      buf_sec_next    = buf_sec_reg;
      sd_lba_next     = sd_lba_reg;
      sd_rd_next      = 1'b0;
      sd_wr_next      = 1'b0;
      cpu_wait_next   = cpu_wait_reg;
      loaded_next     = loaded_reg;
      mount_pend_next = mount_pend_reg;
      clr_all         = 1'b0;
      clr_one         = 1'b0;
      case (state_reg)
         IDLE: begin
            cpu_wait_next = need_load;
`ifdef FDD_WRITEBACK_EN
            if (start_flush) begin
               buf_sec_next = lowest(dirty_reg);
            end else
`endif
            if (need_load) begin
               buf_sec_next   = '0;
               cur_track_next = track;
               clr_all        = 1'b1;
            end
         end
`ifdef FDD_WRITEBACK_EN
         FLUSH_REQ: begin
            sd_lba_next = lba_calc;
            sd_wr_next  = ~ack_rise;
            clr_one     = ack_rise;
         end
         FLUSH_XFER: begin
            if (ack_fall && !abort_reg) begin
               if (remaining != '0) begin
                  buf_sec_next = lowest(remaining);
               end else begin
                  buf_sec_next   = '0;
                  cur_track_next = track;
               end
            end
         end
`endif
         LOAD_REQ: begin
            sd_lba_next = lba_calc;
            sd_rd_next  = ~ack_rise;
         end
         LOAD_XFER: begin
            if (ack_fall && !abort_reg) begin
               if (buf_sec_reg == LAST_SEC) begin
                  loaded_next     = 1'b1;
                  cpu_wait_next   = 1'b0;
                  mount_pend_next = 1'b0;
               end else begin
                  buf_sec_next = buf_sec_reg + SEC_W'(1);
               end
            end
         end
         default: ;
      endcase
      if (img_mounted) begin
         mount_pend_next = 1'b1;
         loaded_next     = 1'b0;
      end
      abort_next = (state_next != IDLE) &
                   (abort_reg | (img_mounted & (state_reg != IDLE)));
   end

   always_comb begin
      busy     = (state_reg != IDLE);
      sd_lba   = sd_lba_reg;
      sd_rd    = sd_rd_reg;
      sd_wr    = sd_wr_reg;
      buf_sec  = buf_sec_reg;
      cpu_wait = cpu_wait_reg;
      dirty    = dirty_reg;
   end
endmodule

// File: tb/tb_fdd_track_ctrl.sv
// Directed bench for fdd_track_ctrl: a vector table of track steps plus hand-written corner sequences.
module tb_fdd_track_ctrl;
   localparam int SECTORS = 13;
   localparam int TRACK_W = 6;
   localparam int SEC_W   = 4;
`ifdef FDD_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   logic               clk_sys = 1'b0;
   logic               reset_n = 1'b0;
   logic [TRACK_W-1:0] track = '0;
   logic               img_mounted = 1'b0;
   logic               img_present = 1'b0;
   logic               img_readonly = 1'b0;
   logic               disk_we = 1'b0;
   logic [SEC_W+8:0]   disk_addr = '0;
   logic [31:0]        sd_lba;
   logic               sd_rd, sd_wr;
   logic               sd_ack = 1'b0;
   logic [SEC_W-1:0]   buf_sec;
   logic               cpu_wait, busy;
   logic [SECTORS-1:0] dirty;

   int tests = 0;
   int fails = 0;

   fdd_track_ctrl #(.SECTORS(SECTORS), .TRACK_W(TRACK_W), .SEC_W(SEC_W)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .track(track),
      .img_mounted(img_mounted), .img_present(img_present), .img_readonly(img_readonly),
      .disk_we(disk_we), .disk_addr(disk_addr),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .buf_sec(buf_sec), .cpu_wait(cpu_wait), .busy(busy), .dirty(dirty)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      bit          mount;
      int          trk;
      bit          ro;
      int          nw;
      logic [12:0] a0, a1;
      logic [12:0] dmask;
      int          nwr;
      int          wlba0, wsec0, wlba1, wsec1;
      int          rd_base;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_req(output bit ok);
      int n;
      n = 0;
      while (!(sd_rd || sd_wr) && n < 200) begin
         @(negedge clk_sys);
         n++;
      end
      ok = (sd_rd || sd_wr);
   endtask

   // Serve one SD block: check the request, ack it, verify the request drops, then end the block.
   task automatic expect_block(input bit exp_wr, input int exp_lba, input int exp_sec);
      bit ok;
      wait_req(ok);
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL req_timeout: no request seen, required lba %0d", exp_lba);
         return;
      end
      $display("[TB] %s lba=%0d buf_sec=%0d", sd_wr ? "wr" : "rd", sd_lba, buf_sec);
      check("req_is_write", 32'(sd_wr), 32'(exp_wr));
      check("req_lba", sd_lba, exp_lba);
      check("req_buf_sec", 32'(buf_sec), exp_sec);
      check("req_cpu_wait", 32'(cpu_wait), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk_sys);
      check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
      repeat (3) @(negedge clk_sys);
      sd_ack = 1'b0;
      @(negedge clk_sys);
   endtask

   task automatic end_of_seq();
      check("done_cpu_wait", 32'(cpu_wait), 32'd0);
      check("done_busy", 32'(busy), 32'd0);
      check("done_dirty", 32'(dirty), 32'd0);
      repeat (5) @(negedge clk_sys);
      check("quiet_req", 32'(sd_rd | sd_wr), 32'd0);
   endtask

   task automatic apply(input vec_t v);
      logic [12:0] dexp;
      int          nwr;
      dexp = WB ? v.dmask : 13'h0;
      nwr  = WB ? v.nwr : 0;
      if (v.mount) begin
         img_mounted = 1'b1;
         img_present = 1'b1;
         @(negedge clk_sys);
         img_mounted = 1'b0;
      end
      img_readonly = v.ro;
      for (int i = 0; i < v.nw; i++) begin
         disk_addr = (i == 0) ? v.a0 : v.a1;
         disk_we   = 1'b1;
         @(negedge clk_sys);
         disk_we   = 1'b0;
      end
      check("dirty_after_writes", 32'(dirty), 32'(dexp));
      track = TRACK_W'(v.trk);
      if (nwr > 0) expect_block(1'b1, v.wlba0, v.wsec0);
      if (nwr > 1) expect_block(1'b1, v.wlba1, v.wsec1);
      for (int i = 0; i < SECTORS; i++) expect_block(1'b0, v.rd_base + i, i);
      end_of_seq();
   endtask

   task automatic set_vec(input int k, input bit mount, input int trk, input bit ro, input int nw,
                          input logic [12:0] a0, input logic [12:0] a1, input logic [12:0] dmask,
                          input int nwr, input int wlba0, input int wsec0, input int wlba1,
                          input int wsec1, input int rd_base);
      vecs[k].mount = mount;  vecs[k].trk = trk;     vecs[k].ro = ro;     vecs[k].nw = nw;
      vecs[k].a0 = a0;        vecs[k].a1 = a1;       vecs[k].dmask = dmask;
      vecs[k].nwr = nwr;      vecs[k].wlba0 = wlba0; vecs[k].wsec0 = wsec0;
      vecs[k].wlba1 = wlba1;  vecs[k].wsec1 = wsec1; vecs[k].rd_base = rd_base;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      //       k mnt trk ro nw  a0        a1        dmask     nwr wlba0 ws0 wlba1 ws1 rd_base
      set_vec(0, 1,  0, 0, 0, 13'h0000, 13'h0000, 13'h0000, 0,  0,   0,  0,    0,  0);
      set_vec(1, 0,  3, 0, 0, 13'h0000, 13'h0000, 13'h0000, 0,  0,   0,  0,    0,  39);
      set_vec(2, 0,  4, 0, 0, 13'h0000, 13'h0000, 13'h0000, 0,  0,   0,  0,    0,  52);
      set_vec(3, 0,  3, 0, 0, 13'h0000, 13'h0000, 13'h0000, 0,  0,   0,  0,    0,  39);
      set_vec(4, 0,  5, 0, 2, 13'h0400, 13'h1800, 13'h1004, 2,  41,  2,  51,   12, 65);
      set_vec(5, 0,  3, 0, 0, 13'h0000, 13'h0000, 13'h0000, 0,  0,   0,  0,    0,  39);
      set_vec(6, 0,  5, 1, 2, 13'h0400, 13'h1800, 13'h1004, 0,  0,   0,  0,    0,  65);
      set_vec(7, 0,  3, 0, 2, 13'h1A00, 13'h1E00, 13'h0000, 0,  0,   0,  0,    0,  39);
      set_vec(8, 0,  4, 0, 1, 13'h03FF, 13'h0000, 13'h0002, 1,  40,  1,  0,    0,  52);

      repeat (3) @(negedge clk_sys);
      check("rst_sd_lba", sd_lba, 32'd0);
      check("rst_sd_rd", 32'(sd_rd), 32'd0);
      check("rst_sd_wr", 32'(sd_wr), 32'd0);
      check("rst_buf_sec", 32'(buf_sec), 32'd0);
      check("rst_cpu_wait", 32'(cpu_wait), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dirty", 32'(dirty), 32'd0);
      reset_n = 1'b1;
      repeat (8) @(negedge clk_sys);
      check("absent_busy", 32'(busy), 32'd0);
      check("absent_cpu_wait", 32'(cpu_wait), 32'd0);
      check("absent_req", 32'(sd_rd | sd_wr), 32'd0);

      for (int k = 0; k < 9; k++) apply(vecs[k]);

      // Track 2 -> 3 while sector 5 of track 2 is pending: track 2 completes first.
      track = 6'd2;
      for (int i = 0; i < SECTORS; i++) begin
         if (i == 5) track = 6'd3;
         expect_block(1'b0, 26 + i, i);
      end
      for (int i = 0; i < SECTORS; i++) expect_block(1'b0, 39 + i, i);
      end_of_seq();

      // Reset while sector 7 of track 6 is in its transfer phase.
      track = 6'd6;
      for (int i = 0; i < 7; i++) expect_block(1'b0, 78 + i, i);
      disk_addr = 13'h0800;
      disk_we   = 1'b1;
      @(negedge clk_sys);
      disk_we   = 1'b0;
      wait_req(ok);
      check("sec7_req_seen", 32'(ok), 32'd1);
      check("sec7_lba", sd_lba, 32'd85);
      sd_ack = 1'b1;
      repeat (2) @(negedge clk_sys);
      check("sec7_busy", 32'(busy), 32'd1);
      check("sec7_dirty", 32'(dirty), WB ? 32'h10 : 32'h0);
      reset_n = 1'b0;
      #1;
      check("midrst_sd_rd", 32'(sd_rd), 32'd0);
      check("midrst_cpu_wait", 32'(cpu_wait), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_dirty", 32'(dirty), 32'd0);
      check("midrst_sd_lba", sd_lba, 32'd0);
      check("midrst_buf_sec", 32'(buf_sec), 32'd0);
      sd_ack = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      for (int i = 0; i < SECTORS; i++) expect_block(1'b0, 78 + i, i);
      end_of_seq();

      // Image removed: a track step must not start any transfer.
      img_present = 1'b0;
      track = 6'd9;
      repeat (10) @(negedge clk_sys);
      check("gone_req", 32'(sd_rd | sd_wr), 32'd0);
      check("gone_cpu_wait", 32'(cpu_wait), 32'd0);
      check("gone_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fdd_track_ctrl.md
Name: fdd_track_ctrl

Overview:
Sequences the floppy track buffer: loads one track (13 × 512-byte sectors) from the SD image into the floppy dual-port RAM, and writes modified sectors back before the track is replaced. Sits between the hps_io SD block-device port 0 (sd_lba/sd_rd/sd_wr/sd_ack) and the disk II track RAM. Drives the CPU wait line while a transfer is in flight. It is the arbiter between read-load and write-back traffic on the single SD channel.

Parameters:
SECTORS, 13, sectors per track; LBA = SECTORS*track + sector
TRACK_W, 6, width of track number
SEC_W, 4, width of sector index

Ports:
clk_sys  in  1  system clock (14 MHz domain)
reset_n  in  1  asynchronous active-low reset
track  in  TRACK_W  current head track from drive logic
img_mounted  in  1  one-cycle pulse: new image mounted on unit 0
img_present  in  1  image size nonzero
img_readonly  in  1  mounted image is write-protected
disk_we  in  1  drive-side write strobe into track RAM
disk_addr  in  SEC_W+9  drive-side track RAM byte address; [12:9] = sector
sd_lba  out  32  block address to hps_io
sd_rd  out  1  read request
sd_wr  out  1  write request
sd_ack  in  1  hps_io transfer acknowledge (high for whole 512-byte block)
buf_sec  out  SEC_W  sector index for track-RAM port A address high bits
cpu_wait  out  1  stall CPU
busy  out  1  state != IDLE
dirty  out  SECTORS  per-sector modified mask

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, buf_sec=0, cpu_wait=0, busy=0, dirty=0, cur_track=0, loaded=0, state=IDLE.
- States: IDLE, FLUSH_REQ, FLUSH_XFER, LOAD_REQ, LOAD_XFER.
- IDLE: need_load = img_present & (mount_pend | ~loaded | track != cur_track). If need_load and (dirty != 0) and ~img_readonly and ~mount_pend -> FLUSH_REQ with buf_sec = lowest set dirty index. Else if need_load -> LOAD_REQ, buf_sec=0, cur_track<=track (latched at entry). cpu_wait<=1 on leaving IDLE.
- FLUSH_REQ: sd_lba=SECTORS*cur_track+buf_sec (computed 32-bit, zero-extended), sd_wr=1. On sd_ack rising edge: sd_wr<=0, clear dirty[buf_sec] -> FLUSH_XFER.
- FLUSH_XFER: on sd_ack falling edge: if remaining dirty != 0 -> FLUSH_REQ with next lowest index; else -> LOAD_REQ, buf_sec=0, cur_track<=track.
- LOAD_REQ: sd_lba=SECTORS*cur_track+buf_sec, sd_rd=1. On sd_ack rising edge: sd_rd<=0 -> LOAD_XFER.
- LOAD_XFER: on sd_ack falling edge: if buf_sec==SECTORS-1 -> IDLE, loaded<=1, cpu_wait<=0, mount_pend<=0; else buf_sec+1 -> LOAD_REQ.
- Edge detection uses a registered sd_ack; request asserted in cycle after state entry, deasserted in cycle after ack rise.
- Dirty mask: disk_we with disk_addr[12:9] < SECTORS sets that bit, any state; indices ≥ SECTORS ignored. Simultaneous set and flush-clear of same bit: set wins.
- img_mounted pulse: mount_pend<=1, dirty<=0, loaded<=0 (old image never flushed). If it arrives mid-transfer, current block finishes, then IDLE re-evaluates and reloads from sector 0.
- Track change mid-load: ignored until load completes; IDLE then sees track != cur_track and starts a new sequence (flush first if dirty).
- img_present=0: IDLE stays idle, cpu_wait=0.
- img_readonly=1: dirty bits discarded (cleared) at next need_load instead of flushed.
- Reset mid-operation: all outputs return to reset values immediately; in-flight hps_io block is abandoned.

Optional Feature:
FDD_WRITEBACK_EN: defined -> dirty tracking and FLUSH_* states as above. Undefined -> dirty output tied 0, sd_wr tied 0, FLUSH states not synthesized; track change goes straight to LOAD_REQ; drive writes live only in track RAM.

Test Plan:
- Mount pulse, img_present=1, track=0 -> 13 reads, sd_lba 0..12, buf_sec 0..12, cpu_wait high throughout, low one cycle after 13th ack fall.
- Loaded track 3, step to 4, no writes -> reads at LBA 52..64, sd_wr never asserted.
- Loaded track 3, disk_we at addr 0x0400 and 0x1800 (sectors 2, 12), step to 5 -> writes LBA 41 then 51, dirty=0, then reads LBA 65..77.
- Same as previous with img_readonly=1 -> no sd_wr, dirty cleared, reads LBA 65..77.
- Track 2→3 while loading sector 5 of track 2 -> track-2 load completes (LBA 26..38), then reads 39..51.
- reset_n low during LOAD_XFER of sector 7 -> sd_rd=0, cpu_wait=0, dirty=0 immediately; after release with img_present=1 full reload from sector 0.
